bitcoin_host_if: RTL and testbench

//  Host-side counterpart of bitcoin_hash. Streams a 20-word block header into shared memory, pulses
//  the hasher's start, and waits for its done. It then reads back the NUM_NONCES result words from
//  the output area and streams them out with their nonce index. It also reports the minimum result

---
 rtl/bitcoin_host_if_if.sv | 46 ++++
 rtl/bitcoin_host_if.sv | 171 +++++++++++++++++
 tb/tb_bitcoin_host_if.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bitcoin_host_if_if.sv
// Bundle of the stream, hasher and shared-memory signals of bitcoin_host_if.
// master = the host block itself, slave = the environment (source, sink, hasher, memory).
interface bitcoin_host_if_if;
  // Job control and header stream
  logic        go;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;

  // Result stream and job status
  logic        out_valid;
  logic [31:0] out_data;
  logic [3:0]  out_nonce;
  logic        out_ready;
  logic [31:0] min_data;
  logic [3:0]  min_nonce;
  logic        busy;

  // Hasher handshake
  logic        bus_grant;
  logic        hash_start;
  logic        hash_done;
  logic [15:0] hash_msg_addr;
  logic [15:0] hash_out_addr;

  // Shared memory port
  logic        mem_clk;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  modport master (
    input  go, in_valid, in_data, out_ready, hash_done, mem_read_data,
    output in_ready, out_valid, out_data, out_nonce, min_data, min_nonce, busy,
           bus_grant, hash_start, hash_msg_addr, hash_out_addr,
           mem_clk, mem_we, mem_addr, mem_write_data
  );

  modport slave (
    output go, in_valid, in_data, out_ready, hash_done, mem_read_data,
    input  in_ready, out_valid, out_data, out_nonce, min_data, min_nonce, busy,
           bus_grant, hash_start, hash_msg_addr, hash_out_addr,
           mem_clk, mem_we, mem_addr, mem_write_data
  );
endinterface

// File: rtl/bitcoin_host_if.sv
// Host side of bitcoin_hash: loads a block header into shared memory, kicks the hasher,
// then streams the per-nonce result words back out while tracking the minimum.
module bitcoin_host_if #(
  parameter int unsigned MSG_WORDS  = 20,
  parameter int unsigned NUM_NONCES = 16,
  parameter logic [15:0] MSG_ADDR   = 16'h0000,
  parameter logic [15:0] OUT_ADDR   = 16'h0030
) (
  input logic               clk,
  input logic               reset_n,
  bitcoin_host_if_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    KICK,
    WAIT,
    RADDR,
    RDATA,
    HOLD
  } state_e;

  localparam int unsigned           WCNT_W    = $clog2(MSG_WORDS);
  localparam logic [WCNT_W-1:0]     WCNT_LAST = WCNT_W'(MSG_WORDS - 1);
  localparam logic [3:0]            RCNT_LAST = 4'(NUM_NONCES - 1);

  state_e            state_q;
  logic [WCNT_W-1:0] wcnt_q;
  logic [3:0]        rcnt_q;
  logic              busy_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [31:0]       out_data_q;
  logic [3:0]        out_nonce_q;
  logic [31:0]       min_data_q;
  logic [3:0]        min_nonce_q;
  logic              bus_grant_q;
  logic              hash_start_q;
  logic              mem_we_q;
  logic [15:0]       mem_addr_q;
  logic [31:0]       mem_wdata_q;

  logic              wr_fire;
  logic              rd_fire;
  logic [3:0]        rcnt_d;

  assign wr_fire = bus.in_valid & in_ready_q;
  assign rd_fire = out_valid_q & bus.out_ready;
  assign rcnt_d  = rcnt_q + 4'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      wcnt_q       <= '0;
      rcnt_q       <= '0;
      busy_q       <= 1'b0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_nonce_q  <= '0;
      min_data_q   <= '1;
      min_nonce_q  <= '0;
      bus_grant_q  <= 1'b1;
      hash_start_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below reads pre-edge
      // register values regardless of statement order.
      mem_we_q     <= 1'b0;
      hash_start_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (bus.go) begin
            wcnt_q      <= '0;
            rcnt_q      <= '0;
            min_data_q  <= '1;
            min_nonce_q <= '0;
            busy_q      <= 1'b1;
            in_ready_q  <= 1'b1;
            state_q     <= LOAD;
          end
        end

        LOAD: begin
          if (wr_fire) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= MSG_ADDR + 16'(wcnt_q);
            mem_wdata_q <= bus.in_data;
            if (wcnt_q == WCNT_LAST) begin
              in_ready_q <= 1'b0;
              state_q    <= KICK;
            end else begin
              wcnt_q <= wcnt_q + 1'b1;
            end
          end
        end

        // The last header write is on the bus this cycle; hand the bus over after it.
        KICK: begin
          hash_start_q <= 1'b1;
          bus_grant_q  <= 1'b0;
          mem_addr_q   <= '0;
          mem_wdata_q  <= '0;
          state_q      <= WAIT;
        end

        WAIT: begin
          if (bus.hash_done) begin
            bus_grant_q <= 1'b1;
            mem_addr_q  <= OUT_ADDR + 16'(rcnt_q);
            state_q     <= RADDR;
          end
        end

        RADDR: begin
          state_q <= RDATA;
        end

        // Read data for the address issued in RADDR is valid now.
        RDATA: begin
          out_data_q  <= bus.mem_read_data;
          out_nonce_q <= rcnt_q;
          out_valid_q <= 1'b1;
          if (bus.mem_read_data < min_data_q) begin
            min_data_q  <= bus.mem_read_data;
            min_nonce_q <= rcnt_q;
          end
          state_q <= HOLD;
        end

        HOLD: begin
          if (rd_fire) begin
            out_valid_q <= 1'b0;
            if (rcnt_q == RCNT_LAST) begin
              busy_q     <= 1'b0;
              mem_addr_q <= '0;
              state_q    <= IDLE;
            end else begin
              rcnt_q     <= rcnt_d;
              mem_addr_q <= OUT_ADDR + 16'(rcnt_d);
              state_q    <= RADDR;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready       = in_ready_q;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_data       = out_data_q;
  assign bus.out_nonce      = out_nonce_q;
  assign bus.min_data       = min_data_q;
  assign bus.min_nonce      = min_nonce_q;
  assign bus.busy           = busy_q;
  assign bus.bus_grant      = bus_grant_q;
  assign bus.hash_start     = hash_start_q;
  assign bus.hash_msg_addr  = MSG_ADDR;
  assign bus.hash_out_addr  = OUT_ADDR;
  assign bus.mem_clk        = clk;
  assign bus.mem_we         = mem_we_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_write_data = mem_wdata_q;

endmodule

// File: tb/tb_bitcoin_host_if.sv
// Scoreboard bench for bitcoin_host_if: header writes and result words are predicted when
// stimulus is driven and compared when the DUT puts them on the memory bus / result stream.
module tb_bitcoin_host_if;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  nonce;
  } res_t;

  logic clk = 1'b0;
  logic reset_n;

  bitcoin_host_if_if bus ();

  bitcoin_host_if dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int hs_total = 0;
  int stall_nonce = -1;

  wr_t  wq[$];
  res_t rq[$];

  logic [31:0] mem [256];
  logic [31:0] pat [16];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Behavioural memory: header area is real storage, result area is what the hasher produced.
  always @(posedge clk) begin
    if (bus.mem_we === 1'b1) mem[bus.mem_addr[7:0]] <= bus.mem_write_data;
    if (bus.mem_addr >= 16'h0030 && bus.mem_addr < 16'h0040)
      bus.mem_read_data <= pat[bus.mem_addr[3:0]];
    else
      bus.mem_read_data <= mem[bus.mem_addr[7:0]];
  end

  // Consumer: holds out_ready low for 5 cycles on the selected nonce.
  initial begin
    int stall_cnt;
    stall_cnt = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bus.busy !== 1'b1) stall_cnt = 0;
      if (bus.out_valid === 1'b1 && int'(bus.out_nonce) == stall_nonce && stall_cnt < 5) begin
        bus.out_ready = 1'b0;
        stall_cnt++;
      end else begin
        bus.out_ready = 1'b1;
      end
    end
  end

  // Monitors: memory writes, hash_start pulses, result words.
  always @(negedge clk) begin
    wr_t  w;
    res_t r;
    if (bus.mem_we === 1'b1) begin
      if (wq.size() == 0) begin
        check("wr_unexpected", 1, 0);
      end else begin
        w = wq.pop_front();
        check("wr_addr", bus.mem_addr, w.addr);
        check("wr_data", bus.mem_write_data, w.data);
      end
    end
    if (bus.hash_start === 1'b1) hs_total++;
    if (bus.out_valid === 1'b1) begin
      if (rq.size() == 0) begin
        check("res_unexpected", 1, 0);
      end else if (bus.out_ready === 1'b1) begin
        r = rq.pop_front();
        check("res_data", bus.out_data, r.data);
        check("res_nonce", bus.out_nonce, r.nonce);
      end else begin
        check("hold_data", bus.out_data, rq[0].data);
        check("hold_nonce", bus.out_nonce, rq[0].nonce);
      end
    end
  end

  task automatic pulse_go();
    bus.go = 1'b1;
    @(posedge clk);
    #1;
    bus.go = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] base, input bit gappy, input bit poke);
    int  i;
    int  guard;
    bit  acc;
    i = 0;
    guard = 0;
    while (i < 20 && guard < 200) begin
      bus.in_valid = 1'b1;
      bus.in_data  = base + i;
      if (poke && i == 7) begin
        bus.go        = 1'b1;
        bus.hash_done = 1'b1;
      end
      acc = (bus.in_ready === 1'b1);
      if (acc) wq.push_back('{addr: 16'(i), data: base + i});
      @(posedge clk);
      #1;
      bus.go        = 1'b0;
      bus.hash_done = 1'b0;
      guard++;
      if (acc) begin
        i++;
        if (gappy && i < 20) begin
          bus.in_valid = 1'b0;
          bus.in_data  = 32'hDEADBEEF;
          check("gap_in_ready", bus.in_ready, 1);
          @(posedge clk);
          #1;
        end
      end
    end
    bus.in_valid = 1'b0;
    bus.in_data  = 32'hDEADBEEF;
    check("load_timeout", i, 20);
    // Last write is on the bus now; hash_start must follow exactly one clock later.
    check("last_we", bus.mem_we, 1);
    check("kick_hs_early", bus.hash_start, 0);
    check("kick_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1;
    check("hs_pulse", bus.hash_start, 1);
    check("wait_grant", bus.bus_grant, 0);
    check("wait_we", bus.mem_we, 0);
    @(posedge clk);
    #1;
    check("hs_single", bus.hash_start, 0);
    check("wr_pending", wq.size(), 0);
    for (int k = 0; k < 20; k++) check("hdr_mem", mem[k], base + k);
  endtask

  task automatic run_job(input logic [31:0] base, input bit gappy, input bit poke, input int stall_n);
    logic [31:0] exp_min;
    logic [3:0]  exp_nonce;
    int          hs0;
    exp_min   = 32'hFFFFFFFF;
    exp_nonce = 4'd0;
    for (int k = 0; k < 16; k++) begin
      rq.push_back('{data: pat[k], nonce: 4'(k)});
      if (pat[k] < exp_min) begin
        exp_min   = pat[k];
        exp_nonce = 4'(k);
      end
    end
    stall_nonce = stall_n;
    hs0 = hs_total;

    pulse_go();
    check("go_busy", bus.busy, 1);
    check("go_in_ready", bus.in_ready, 1);
    check("go_min_clear", bus.min_data, 32'hFFFFFFFF);

    do_load(base, gappy, poke);

    repeat (100) @(posedge clk);
    #1;
    check("wait_no_out", bus.out_valid, 0);
    check("wait_grant_hold", bus.bus_grant, 0);
    check("wait_addr", bus.mem_addr, 0);
    check("wait_busy", bus.busy, 1);
    bus.hash_done = 1'b1;
    @(posedge clk);
    #1;
    bus.hash_done = 1'b0;
    check("done_grant", bus.bus_grant, 1);

    for (int c = 0; c < 2000 && (rq.size() != 0 || bus.busy === 1'b1); c++) @(posedge clk);
    #1;
    check("results_timeout", (rq.size() == 0 && bus.busy === 1'b0), 1);
    check("end_out_valid", bus.out_valid, 0);
    check("min_data", bus.min_data, exp_min);
    check("min_nonce", bus.min_nonce, exp_nonce);
    check("hs_count", hs_total - hs0, 1);
    stall_nonce = -1;
    rq.delete();
  endtask

  task automatic abort_in_wait();
    pulse_go();
    do_load(32'h400, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("rst_grant", bus.bus_grant, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_hs", bus.hash_start, 0);
    check("rst_min", bus.min_data, 32'hFFFFFFFF);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_out_valid", bus.out_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n       = 1'b0;
    bus.go        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.hash_done = 1'b0;
    for (int k = 0; k < 16; k++) pat[k] = 32'h50 - k;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_in_ready", bus.in_ready, 0);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_grant", bus.bus_grant, 1);
    check("reset_we", bus.mem_we, 0);
    check("reset_min", bus.min_data, 32'hFFFFFFFF);
    check("reset_hs", bus.hash_start, 0);
    check("msg_addr", bus.hash_msg_addr, 16'h0000);
    check("out_addr", bus.hash_out_addr, 16'h0030);

    // Back-to-back header, descending results.
    run_job(32'h100, 1'b0, 1'b0, -1);

    // Gappy header with go/hash_done pokes during LOAD, consumer stall on nonce 3.
    run_job(32'h200, 1'b1, 1'b1, 3);

    abort_in_wait();

    // Equal minima: lowest nonce must win.
    for (int k = 0; k < 16; k++) pat[k] = 32'h1000 + k;
    pat[2] = 32'h7;
    pat[9] = 32'h7;
    run_job(32'h300, 1'b0, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
